// File: rtl/score_counter_multi_pkg.sv
// Shared constants for the multi-channel score counter: default sizing,
// wrap/saturate mode encodings, and the optional BCD digit helper
// (the helper is present only when SCORE_BCD_EN is defined).
package score_counter_multi_pkg;

  localparam int DEF_NUM_CH  = 2;
  localparam int DEF_BW      = 7;
  localparam int DEF_MAX_VAL = 99;

  // wrap_i encodings
  localparam logic WRAP_MODE_SAT  = 1'b0;
  localparam logic WRAP_MODE_WRAP = 1'b1;

`ifdef SCORE_BCD_EN
  // Largest value two BCD digits can show
  localparam int BCD_MAX_VAL = 99;

  // Binary 0..99 to {tens, ones}; constant divisors keep this a small comb block
  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 8'd10);
    ones = 4'(v % 8'd10);
    return {tens, ones};
  endfunction
`endif

endpackage

// File: rtl/score_channel.sv
// One score channel: strobe synchronisers, rising-edge detect, count register, limit logic.
// Latency: strobe first sampled high at edge k changes the count at edge k+2; flags are comb.
// Backpressure: none; every detected edge is applied immediately or dropped (clear, up+down).
module score_channel
  import score_counter_multi_pkg::*;
#(
  parameter int BW      = DEF_BW,
  parameter int MAX_VAL = DEF_MAX_VAL
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          up_i,
  input  logic          down_i,
  input  logic          wrap_i,
  input  logic          clear_i,
  output logic [BW-1:0] count_o,
  output logic          at_max_o,
  output logic          at_min_o
);

  localparam logic [BW-1:0] MAX_C = BW'(MAX_VAL);

  logic          up_s1, up_s2, up_h;
  logic          dn_s1, dn_s2, dn_h;
  logic          up_edge, dn_edge;
  logic [BW-1:0] count_q, count_d;

  // Two-flop synchronisers plus history; reset high so a held strobe is not an edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      up_s1 <= 1'b1;
      up_s2 <= 1'b1;
      up_h  <= 1'b1;
      dn_s1 <= 1'b1;
      dn_s2 <= 1'b1;
      dn_h  <= 1'b1;
    end else begin
      up_s1 <= up_i;
      up_s2 <= up_s1;
      up_h  <= up_s2;
      dn_s1 <= down_i;
      dn_s2 <= dn_s1;
      dn_h  <= dn_s2;
    end
  end

  assign up_edge = up_s2 & ~up_h;
  assign dn_edge = dn_s2 & ~dn_h;

  // Next count: clear wins, simultaneous up+down cancels, limits checked before +/-1
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (up_edge && !dn_edge) begin
      if (count_q < MAX_C)
        count_d = count_q + BW'(1);
      else if (wrap_i == WRAP_MODE_SAT)
        count_d = MAX_C;
      else
        count_d = '0;
    end else if (dn_edge && !up_edge) begin
      if (count_q != '0)
        count_d = count_q - BW'(1);
      else if (wrap_i == WRAP_MODE_WRAP)
        count_d = MAX_C;
      else
        count_d = '0;
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count_o  = count_q;
  assign at_max_o = (count_q == MAX_C);
  assign at_min_o = (count_q == '0);

endmodule

// File: rtl/score_counter_multi.sv
// Multi-channel up/down score counter; optional registered BCD output when SCORE_BCD_EN is defined.
// Latency: strobe sampled high at edge k updates counts_o at edge k+2; bcd_o lags counts_o by 1.
// Backpressure: none; strobes are edge-detected and consumed every cycle.
module score_counter_multi
  import score_counter_multi_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int BW      = DEF_BW,
  parameter int MAX_VAL = DEF_MAX_VAL
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CH-1:0]    up_i,
  input  logic [NUM_CH-1:0]    down_i,
  input  logic                 wrap_i,
  input  logic                 clear_i,
  output logic [NUM_CH*BW-1:0] counts_o,
  output logic [NUM_CH-1:0]    at_max_o,
  output logic [NUM_CH-1:0]    at_min_o
`ifdef SCORE_BCD_EN
  ,
  output logic [NUM_CH*8-1:0]  bcd_o
`endif
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("score_counter_multi: NUM_CH must be at least 1");
  end
  if (MAX_VAL >= (1 << BW)) begin : g_bad_bw
    $error("score_counter_multi: MAX_VAL does not fit in BW bits");
  end

  logic [BW-1:0] ch_count [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    score_channel #(
      .BW      (BW),
      .MAX_VAL (MAX_VAL)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .up_i     (up_i[c]),
      .down_i   (down_i[c]),
      .wrap_i   (wrap_i),
      .clear_i  (clear_i),
      .count_o  (ch_count[c]),
      .at_max_o (at_max_o[c]),
      .at_min_o (at_min_o[c])
    );
    assign counts_o[c*BW +: BW] = ch_count[c];
  end

`ifdef SCORE_BCD_EN
  if (MAX_VAL > BCD_MAX_VAL) begin : g_bad_bcd
    $error("score_counter_multi: MAX_VAL too large for two BCD digits");
  end

  logic [NUM_CH*8-1:0] bcd_q;

  // Convert each channel count to BCD one cycle behind the count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bcd_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        bcd_q[c*8 +: 8] <= to_bcd(8'(ch_count[c]));
    end
  end

  assign bcd_o = bcd_q;
`endif

endmodule

// File: tb/tb_score_counter_multi.sv
// Directed bench for score_counter_multi with an expectation queue.
// A behavioural count model drives expectations; each check pops one entry.
// Build with SCORE_BCD_EN defined to also cover the BCD output.
module tb_score_counter_multi;

  localparam int NUM_CH  = 2;
  localparam int BW      = 7;
  localparam int MAX_VAL = 99;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic [NUM_CH-1:0]    up_i;
  logic [NUM_CH-1:0]    down_i;
  logic                 wrap_i;
  logic                 clear_i;
  logic [NUM_CH*BW-1:0] counts_o;
  logic [NUM_CH-1:0]    at_max_o;
  logic [NUM_CH-1:0]    at_min_o;
`ifdef SCORE_BCD_EN
  logic [NUM_CH*8-1:0]  bcd_o;
`endif

  always #5 clk = ~clk;

  score_counter_multi #(
    .NUM_CH  (NUM_CH),
    .BW      (BW),
    .MAX_VAL (MAX_VAL)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .up_i     (up_i),
    .down_i   (down_i),
    .wrap_i   (wrap_i),
    .clear_i  (clear_i),
    .counts_o (counts_o),
    .at_max_o (at_max_o),
    .at_min_o (at_min_o)
`ifdef SCORE_BCD_EN
    ,
    .bcd_o    (bcd_o)
`endif
  );

  typedef struct packed {
    logic [NUM_CH*BW-1:0] counts;
    logic [NUM_CH-1:0]    at_max;
    logic [NUM_CH-1:0]    at_min;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];
  int    checks = 0;
  int    errors = 0;
  int    m_cnt [NUM_CH];

  function automatic int m_up(input int v, input logic wrap);
    if (v < MAX_VAL) return v + 1;
    return wrap ? 0 : MAX_VAL;
  endfunction

  function automatic int m_dn(input int v, input logic wrap);
    if (v > 0) return v - 1;
    return wrap ? MAX_VAL : 0;
  endfunction

  function automatic logic [7:0] m_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      e.counts[c*BW +: BW] = BW'(m_cnt[c]);
      e.at_max[c] = (m_cnt[c] == MAX_VAL);
      e.at_min[c] = (m_cnt[c] == 0);
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_pop();
    exp_t  e;
    string t;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty got 0 entries expected 1");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (counts_o === e.counts) else begin
        errors++;
        $error("FAIL %s counts got %h expected %h", t, counts_o, e.counts);
      end
      checks++;
      assert (at_max_o === e.at_max) else begin
        errors++;
        $error("FAIL %s at_max got %b expected %b", t, at_max_o, e.at_max);
      end
      checks++;
      assert (at_min_o === e.at_min) else begin
        errors++;
        $error("FAIL %s at_min got %b expected %b", t, at_min_o, e.at_min);
      end
    end
  endtask

  task automatic expect_state(input string tag);
    push_exp(tag);
    check_pop();
  endtask

`ifdef SCORE_BCD_EN
  task automatic check_bcd(input string tag, input int v0, input int v1);
    logic [15:0] exp_b;
    exp_b = {m_bcd(v1), m_bcd(v0)};
    checks++;
    assert (bcd_o === exp_b) else begin
      errors++;
      $error("FAIL %s bcd got %h expected %h", tag, bcd_o, exp_b);
    end
  endtask
`endif

  // Strobe held two cycles, then three idle cycles so the count has settled
  task automatic pulse(input logic [NUM_CH-1:0] up, input logic [NUM_CH-1:0] dn);
    up_i   = up;
    down_i = dn;
    cyc(2);
    up_i   = '0;
    down_i = '0;
    cyc(3);
    for (int c = 0; c < NUM_CH; c++) begin
      if (up[c] && !dn[c])      m_cnt[c] = m_up(m_cnt[c], wrap_i);
      else if (dn[c] && !up[c]) m_cnt[c] = m_dn(m_cnt[c], wrap_i);
    end
  endtask

  initial begin
    rst_i   = 1'b1;
    up_i    = '1;
    down_i  = '0;
    wrap_i  = 1'b0;
    clear_i = 1'b0;
    for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;

    // 1: reset with up held high, release, no count appears
    cyc(3);
    expect_state("reset");
`ifdef SCORE_BCD_EN
    check_bcd("reset_bcd", 0, 0);
`endif
    rst_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      expect_state("held_up_after_reset");
    end
    up_i = '0;
    cyc(4);
    expect_state("held_up_dropped");

    // 2: ch0 saturates at MAX_VAL after 100 up pulses
    wrap_i = 1'b0;
    for (int i = 0; i < 50; i++) pulse(2'b01, 2'b00);
    expect_state("ch0_mid50");
    for (int i = 0; i < 50; i++) pulse(2'b01, 2'b00);
    expect_state("ch0_saturate_99");

    // 3: wrap mode round trip
    wrap_i = 1'b1;
    pulse(2'b01, 2'b00);
    expect_state("ch0_wrap_up_to_0");
    pulse(2'b00, 2'b01);
    expect_state("ch0_wrap_down_to_99");
    wrap_i = 1'b0;

    // 4: simultaneous up/down on one channel cancels; channels independent
    for (int i = 0; i < 5; i++) pulse(2'b10, 2'b00);
    expect_state("ch1_at_5");
    pulse(2'b10, 2'b10);
    expect_state("ch1_updown_same_edge");
    pulse(2'b10, 2'b01);
    expect_state("independent_channels");

    // 5: clear overrides an edge in the same cycle and the edge is lost
    while (m_cnt[0] > 40) pulse(2'b00, 2'b01);
    pulse(2'b10, 2'b00);
    expect_state("pre_clear_40_7");
    up_i = 2'b01;
    cyc(2);
    clear_i = 1'b1;
    up_i    = '0;
    cyc(1);
    clear_i = 1'b0;
    for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
    cyc(3);
    expect_state("clear_beats_edge");
    cyc(10);
    expect_state("clear_no_late_inc");

    // 6: exact two-edge latency, and BCD one cycle later
    for (int i = 0; i < 41; i++) pulse(2'b01, 2'b00);
    expect_state("ch0_41");
    up_i = 2'b01;
    cyc(1);
    expect_state("latency_edge_k");
    cyc(1);
    expect_state("latency_edge_k1");
    up_i = '0;
    cyc(1);
    m_cnt[0] = 42;
    expect_state("latency_edge_k2");
`ifdef SCORE_BCD_EN
    check_bcd("bcd_lags_count", 41, 0);
    cyc(1);
    check_bcd("bcd_42", 42, 0);
`endif
    cyc(3);

    // Reset mid-count returns everything to zero
    rst_i = 1'b1;
    cyc(1);
    for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
    expect_state("reset_mid_count");
    cyc(1);
    rst_i = 1'b0;
    cyc(4);
    expect_state("after_mid_reset");

    // Down at zero saturates when wrap is off
    pulse(2'b00, 2'b10);
    expect_state("ch1_saturate_low");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
